// File: rtl/radix2_stage_ctrl.sv
// Single-clock frame sequencer for one radix-2 FFT stage: pairs input samples,
// waits for the butterfly, then drains the y2 FIFO through the twiddle multiplier.
module radix2_stage_ctrl #(
   parameter int HALF_LEN     = 12,
   parameter int TF_ADDR_LEN  = 12,
   parameter int STRIDE_SHIFT = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   buf_wr_en,
   output logic                   pair_valid,
   input  logic                   bf_valid,
   input  logic                   y2_empty,
   output logic                   y2_rd_en,
   output logic [TF_ADDR_LEN-1:0] tf_addr,
   output logic                   tf_valid,
   input  logic                   mul_valid,
   output logic                   out_valid,
   output logic                   out_sel,
   output logic                   frame_done,
   output logic [2:0]             err
);

   localparam logic [2:0] FILL    = 3'd0;
   localparam logic [2:0] PAIR    = 3'd1;
   localparam logic [2:0] WAIT_BF = 3'd2;
   localparam logic [2:0] DRAIN   = 3'd3;
   localparam logic [2:0] FLUSH   = 3'd4;

   localparam logic [HALF_LEN-1:0] CNT_LAST = '1;
   localparam logic [HALF_LEN-1:0] CNT_ONE  = HALF_LEN'(1);

   logic [2:0]             state_q, state_d;
   logic [HALF_LEN-1:0]    in_cnt_q, in_cnt_d;
   logic [HALF_LEN-1:0]    bf_cnt_q, bf_cnt_d;
   logic [HALF_LEN-1:0]    rd_cnt_q, rd_cnt_d;
   logic [HALF_LEN-1:0]    mul_cnt_q, mul_cnt_d;
   logic                   tf_valid_q, tf_valid_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_sel_q, out_sel_d;
   logic                   frame_done_q, frame_done_d;
   logic [2:0]             err_q, err_d;
   logic                   accept;
   logic                   mul_take;
   logic [TF_ADDR_LEN-1:0] rd_addr;

   always_comb begin
      state_d      = state_q;
      in_cnt_d     = in_cnt_q;
      bf_cnt_d     = bf_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      mul_cnt_d    = mul_cnt_q;

      in_ready   = (state_q == FILL) || (state_q == PAIR);
      buf_wr_en  = (state_q == FILL) && in_valid;
      pair_valid = (state_q == PAIR) && in_valid;
      y2_rd_en   = (state_q == DRAIN);
      accept     = in_valid && in_ready;
      mul_take   = mul_valid && ((state_q == DRAIN) || (state_q == FLUSH));

      // rd_cnt returns to 0 after each drain, so the address idles at 0
      rd_addr = TF_ADDR_LEN'(rd_cnt_q);
      tf_addr = rd_addr << STRIDE_SHIFT;

      if (accept)    in_cnt_d  = in_cnt_q + CNT_ONE;
      if (bf_valid)  bf_cnt_d  = bf_cnt_q + CNT_ONE;
      if (y2_rd_en)  rd_cnt_d  = rd_cnt_q + CNT_ONE;
      if (mul_take)  mul_cnt_d = mul_cnt_q + CNT_ONE;

      case (state_q)
         FILL:    if (accept && (in_cnt_q == CNT_LAST)) state_d = PAIR;
         PAIR:    if (accept && (in_cnt_q == CNT_LAST)) state_d = WAIT_BF;
         WAIT_BF: if (bf_valid && (bf_cnt_q == CNT_LAST)) state_d = DRAIN;
         DRAIN:   if (rd_cnt_q == CNT_LAST) state_d = FLUSH;
         FLUSH:   if (mul_valid && (mul_cnt_q == CNT_LAST)) state_d = FILL;
         default: state_d = FILL;
      endcase

      tf_valid_d   = y2_rd_en;
      // multiplier result has priority if both paths ever collide
      out_valid_d  = bf_valid || mul_valid;
      out_sel_d    = mul_valid;
      frame_done_d = (state_q == FLUSH) && mul_valid && (mul_cnt_q == CNT_LAST);
      err_d        = err_q | {bf_valid && mul_valid,
                              y2_rd_en && y2_empty,
                              in_valid && !in_ready};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= FILL;
         in_cnt_q     <= '0;
         bf_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         mul_cnt_q    <= '0;
         tf_valid_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sel_q    <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 3'b000;
      end else begin
         state_q      <= state_d;
         in_cnt_q     <= in_cnt_d;
         bf_cnt_q     <= bf_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         mul_cnt_q    <= mul_cnt_d;
         tf_valid_q   <= tf_valid_d;
         out_valid_q  <= out_valid_d;
         out_sel_q    <= out_sel_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign tf_valid   = tf_valid_q;
   assign out_valid  = out_valid_q;
   assign out_sel    = out_sel_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_radix2_stage_ctrl.sv
// Scoreboard bench for radix2_stage_ctrl: butterfly and multiplier are modelled as
// fixed-latency delay lines fed back from the controller's own strobes.
module tb_radix2_stage_ctrl;

   localparam int HL   = 2;
   localparam int HALF = 4;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic y2_empty = 1'b0;
   logic inj = 1'b0;
   logic bf_valid, mul_valid;
   logic [2:0] bf_sr;
   logic [5:0] mul_sr;

   logic          a_in_ready, a_buf_wr_en, a_pair_valid, a_y2_rd_en, a_tf_valid;
   logic          a_out_valid, a_out_sel, a_frame_done;
   logic [AW-1:0] a_tf_addr;
   logic [2:0]    a_err;
   logic          b_in_ready, b_buf_wr_en, b_pair_valid, b_y2_rd_en, b_tf_valid;
   logic          b_out_valid, b_out_sel, b_frame_done;
   logic [AW-1:0] b_tf_addr;
   logic [2:0]    b_err;

   always #5 clk = ~clk;

   radix2_stage_ctrl #(.HALF_LEN(HL), .TF_ADDR_LEN(AW), .STRIDE_SHIFT(0)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .buf_wr_en(a_buf_wr_en), .pair_valid(a_pair_valid), .bf_valid(bf_valid),
      .y2_empty(y2_empty), .y2_rd_en(a_y2_rd_en), .tf_addr(a_tf_addr),
      .tf_valid(a_tf_valid), .mul_valid(mul_valid), .out_valid(a_out_valid),
      .out_sel(a_out_sel), .frame_done(a_frame_done), .err(a_err));

   radix2_stage_ctrl #(.HALF_LEN(HL), .TF_ADDR_LEN(AW), .STRIDE_SHIFT(3)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .buf_wr_en(b_buf_wr_en), .pair_valid(b_pair_valid), .bf_valid(bf_valid),
      .y2_empty(y2_empty), .y2_rd_en(b_y2_rd_en), .tf_addr(b_tf_addr),
      .tf_valid(b_tf_valid), .mul_valid(mul_valid), .out_valid(b_out_valid),
      .out_sel(b_out_sel), .frame_done(b_frame_done), .err(b_err));

   // butterfly latency 3 from pair_valid, multiplier latency 6 from y2_rd_en
   always @(posedge clk) begin
      if (!rst) begin
         bf_sr  <= '0;
         mul_sr <= '0;
      end else begin
         bf_sr  <= {bf_sr[1:0], a_pair_valid};
         mul_sr <= {mul_sr[4:0], a_y2_rd_en};
      end
   end
   assign bf_valid  = bf_sr[2] | inj;
   assign mul_valid = mul_sr[5] | inj;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   int cyc = 0;
   int cyc0 = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int exp_sel[$];
   int exp_addr_a[$];
   int exp_addr_b[$];

   int wr_n, wr_first, wr_last, pv_n, pv_first, pv_last;
   int rd_n, rd_first, bf_n, bf4, fd_n, fd_cyc, out1_n, rdy_low_first, rc;
   logic prev_rd = 1'b0;
   logic [10:0] ctrl_a, ctrl_b;

   task automatic clear_stats();
      cyc0 = cyc;
      wr_n = 0; wr_first = -1; wr_last = -1;
      pv_n = 0; pv_first = -1; pv_last = -1;
      rd_n = 0; rd_first = -1; bf_n = 0; bf4 = -1;
      fd_n = 0; fd_cyc = -1; out1_n = 0; rdy_low_first = -1;
   endtask

   assign ctrl_a = {a_in_ready, a_buf_wr_en, a_pair_valid, a_y2_rd_en, a_tf_valid,
                    a_out_valid, a_out_sel, a_frame_done, a_err};
   assign ctrl_b = {b_in_ready, b_buf_wr_en, b_pair_valid, b_y2_rd_en, b_tf_valid,
                    b_out_valid, b_out_sel, b_frame_done, b_err};

   always @(negedge clk) begin
      if (rst) begin
         rc = cyc - cyc0;
         check_eq("dut_b_ctrl", 32'(ctrl_b), 32'(ctrl_a));
         if (a_buf_wr_en) begin
            if (wr_n == 0) wr_first = rc;
            wr_last = rc;
            wr_n++;
         end
         if (a_pair_valid) begin
            if (pv_n == 0) pv_first = rc;
            pv_last = rc;
            pv_n++;
         end
         if (!a_in_ready && rdy_low_first < 0) rdy_low_first = rc;
         if (bf_valid) begin
            bf_n++;
            if (bf_n == HALF) bf4 = rc;
         end
         if (a_y2_rd_en) begin
            if (rd_n == 0) rd_first = rc;
            rd_n++;
            if (exp_addr_a.size() == 0) begin
               check_eq("rd_unexpected", 32'(a_y2_rd_en), 32'd0);
            end else begin
               check_eq("tf_addr_s0", 32'(a_tf_addr), 32'(exp_addr_a.pop_front()));
               check_eq("tf_addr_s3", 32'(b_tf_addr), 32'(exp_addr_b.pop_front()));
            end
         end
         if (a_tf_valid || prev_rd) check_eq("tf_valid_trail", 32'(a_tf_valid), 32'(prev_rd));
         if (a_out_valid) begin
            if (a_out_sel) out1_n++;
            if (exp_sel.size() == 0) check_eq("out_unexpected", 32'(a_out_valid), 32'd0);
            else check_eq("out_sel", 32'(a_out_sel), 32'(exp_sel.pop_front()));
         end
         if (a_frame_done) begin
            fd_n++;
            fd_cyc = rc;
         end
         prev_rd = a_y2_rd_en;
      end else begin
         prev_rd = 1'b0;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_in_ready"},   32'(a_in_ready), 32'd1);
      check_eq({tag, "_buf_wr_en"},  32'(a_buf_wr_en), 32'd0);
      check_eq({tag, "_pair_valid"}, 32'(a_pair_valid), 32'd0);
      check_eq({tag, "_y2_rd_en"},   32'(a_y2_rd_en), 32'd0);
      check_eq({tag, "_tf_addr"},    32'(a_tf_addr), 32'd0);
      check_eq({tag, "_tf_addr_b"},  32'(b_tf_addr), 32'd0);
      check_eq({tag, "_tf_valid"},   32'(a_tf_valid), 32'd0);
      check_eq({tag, "_out_valid"},  32'(a_out_valid), 32'd0);
      check_eq({tag, "_out_sel"},    32'(a_out_sel), 32'd0);
      check_eq({tag, "_frame_done"}, 32'(a_frame_done), 32'd0);
      check_eq({tag, "_err"},        32'(a_err), 32'd0);
   endtask

   // mode 0: contiguous, 1: one-on/two-off, 2: held high past the input window
   task automatic run_frame(input int mode, input string tag, input logic [2:0] exp_err);
      int n_in;
      logic seen;
      clear_stats();
      for (int i = 0; i < HALF; i++) exp_sel.push_back(0);
      for (int i = 0; i < HALF; i++) exp_sel.push_back(1);
      for (int i = 0; i < HALF; i++) begin
         exp_addr_a.push_back(i);
         exp_addr_b.push_back((i << 3) % (1 << AW));
      end
      n_in = (mode == 0) ? 2 * HALF : (mode == 1) ? 6 * HALF : 2 * HALF + 6;
      for (int i = 0; i < n_in; i++) begin
         in_valid = (mode != 1) || (i % 3 == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (a_frame_done) seen = 1'b1;
      end
      check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check_eq({tag, "_wr_n"},    32'(wr_n), 32'(HALF));
      check_eq({tag, "_pair_n"},  32'(pv_n), 32'(HALF));
      check_eq({tag, "_rd_n"},    32'(rd_n), 32'(HALF));
      check_eq({tag, "_mul_out"}, 32'(out1_n), 32'(HALF));
      check_eq({tag, "_fd_n"},    32'(fd_n), 32'd1);
      check_eq({tag, "_sb_left"}, 32'(exp_sel.size()), 32'd0);
      check_eq({tag, "_addr_left"}, 32'(exp_addr_a.size()), 32'd0);
      check_eq({tag, "_err"},     32'(a_err), 32'(exp_err));
   endtask

   task automatic check_exact(input string tag);
      check_eq({tag, "_wr_first"}, 32'(wr_first), 32'd0);
      check_eq({tag, "_wr_last"},  32'(wr_last), 32'd3);
      check_eq({tag, "_pv_first"}, 32'(pv_first), 32'd4);
      check_eq({tag, "_pv_last"},  32'(pv_last), 32'd7);
      check_eq({tag, "_rdy_low"},  32'(rdy_low_first), 32'd8);
      check_eq({tag, "_bf4"},      32'(bf4), 32'd10);
      check_eq({tag, "_rd_first"}, 32'(rd_first), 32'd11);
      check_eq({tag, "_fd_cyc"},   32'(fd_cyc), 32'd21);
   endtask

   initial begin
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst0");
      rst = 1'b1;
      @(posedge clk); #1;

      run_frame(0, "contig", 3'b000);
      check_exact("contig");
      run_frame(1, "gapped", 3'b000);
      run_frame(2, "held", 3'b001);
      run_frame(0, "after_held", 3'b001);

      y2_empty = 1'b1;
      run_frame(0, "empty", 3'b011);
      y2_empty = 1'b0;

      exp_sel.push_back(1);
      inj = 1'b1;
      @(posedge clk); #1;
      inj = 1'b0;
      check_eq("inj_err", 32'(a_err), 32'd7);
      check_eq("inj_out_sel", 32'(a_out_sel), 32'd1);
      @(posedge clk); #1;
      check_eq("inj_sb_left", 32'(exp_sel.size()), 32'd0);

      clear_stats();
      in_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check_reset_outputs("midpair");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_sel.delete();
      exp_addr_a.delete();
      exp_addr_b.delete();
      @(posedge clk); #1;

      run_frame(0, "post_rst", 3'b000);
      check_exact("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/radix2_stage_ctrl.md
Name: radix2_stage_ctrl

Overview:
- Frame sequencer for one radix-2 FFT stage: input pairing buffer, butterfly, y2 FIFO, twiddle ROM and complex multiplier.
- Replaces the asynchronous full/empty read-enable scheme with a single-clock FSM.
- Generates buffer write, butterfly operand valid, y2 FIFO read, twiddle address/valid, and output-mux select/valid.
- Applies input backpressure so y1 and multiplier results never collide at the stage output.

Parameters:
HALF_LEN, 12, log2 of half-frame size; HALF = 2^HALF_LEN samples per butterfly input
TF_ADDR_LEN, 12, twiddle ROM address width
STRIDE_SHIFT, 0, twiddle address = k << STRIDE_SHIFT, truncated to TF_ADDR_LEN

Ports:
clk  input  1  stage clock, all logic rising-edge
rst  input  1  asynchronous active-low reset (0 = reset)
in_valid  input  1  upstream sample valid
in_ready  output  1  stage accepts samples (combinational from state)
buf_wr_en  output  1  write current sample into x1 pairing buffer
pair_valid  output  1  x1 (buffer) and x2 (input) present to butterfly
bf_valid  input  1  butterfly y1/y2 valid (y2 written to FIFO by this strobe)
y2_empty  input  1  y2 FIFO empty
y2_rd_en  output  1  y2 FIFO read; dout valid next cycle
tf_addr  output  TF_ADDR_LEN  twiddle ROM address, issued with y2_rd_en
tf_valid  output  1  y2_rd_en delayed 1 cycle; multiplier operand valid
mul_valid  input  1  multiplier result valid
out_valid  output  1  registered stage output valid
out_sel  output  1  registered mux select: 0 = y1 path, 1 = multiplier
frame_done  output  1  1-cycle pulse after last multiplier result of a frame
err  output  3  sticky: [0] input dropped, [1] read of empty FIFO, [2] bf_valid and mul_valid same cycle

Behaviour:
- Reset (rst=0, async): state FILL, all counters 0; tf_valid, out_valid, out_sel, frame_done, err = 0; tf_addr = 0. Mid-frame reset abandons the frame; the first in_valid after release is sample 0.
- Counters: in_cnt, bf_cnt, rd_cnt, mul_cnt, each HALF_LEN bits, wrap HALF-1 -> 0.
- FSM states: FILL, PAIR, WAIT_BF, DRAIN, FLUSH.
- in_ready = 1 only in FILL and PAIR.
- FILL: buf_wr_en = in_valid. in_cnt++ per in_valid. At in_cnt==HALF-1 with in_valid -> PAIR.
- PAIR: pair_valid = in_valid. At in_cnt==HALF-1 with in_valid -> WAIT_BF.
- bf_cnt increments on bf_valid in any state. WAIT_BF: bf_valid with bf_cnt==HALF-1 -> DRAIN (bf_valid never precedes PAIR exit, BF latency >= 1).
- DRAIN: y2_rd_en = 1 every cycle; tf_addr = rd_cnt << STRIDE_SHIFT. rd_cnt++ per cycle; at HALF-1 -> FLUSH. Exactly HALF reads.
- tf_valid <= y2_rd_en; aligns with FIFO dout and 1-cycle ROM.
- mul_cnt increments on mul_valid in DRAIN and FLUSH. FLUSH: mul_valid with mul_cnt==HALF-1 -> FILL; frame_done=1 the next cycle.
- Output register: out_valid <= bf_valid | mul_valid; out_sel <= mul_valid (multiplier wins).
- Output order per frame: HALF y1 results, then HALF twiddled y2 results.
- Errors, sticky until reset:
  - err[0]: in_valid while in_ready=0; sample is ignored.
  - err[1]: y2_rd_en while y2_empty; the read is still issued.
  - err[2]: bf_valid & mul_valid in the same cycle.
- In-state conditions:
  - bf_valid in FILL: counted, no state change.
  - mul_valid outside DRAIN/FLUSH: ignored, no count.
- Back-to-back frames: FILL re-entered the cycle after the last mul_valid; no idle cycle required.

Test Plan:
- HALF_LEN=2, BF latency 3, MUL latency 6; in_valid high cycles 0-7.
  - Required: buf_wr_en cycles 0-3; pair_valid 4-7; in_ready low from cycle 8.
  - Required: y2_rd_en 4 cycles starting the cycle after the 4th bf_valid; tf_addr 0,1,2,3.
  - Required: out_sel=0 for 4 outputs, then out_sel=1 for 4 outputs; frame_done a single pulse.
- STRIDE_SHIFT=3, TF_ADDR_LEN=5 -> tf_addr sequence 0,8,16,24; tf_valid trails y2_rd_en by exactly 1 cycle.
- in_valid gapped (1 on, 2 off) -> identical control sequence, counts of 4/4/4/4 preserved; err stays 0.
- in_valid held high through DRAIN -> err[0]=1 sticky, no extra buf_wr_en/pair_valid; the next frame starts cleanly after frame_done.
- y2_empty forced high in DRAIN -> err[1]=1. Injected simultaneous bf_valid/mul_valid -> err[2]=1, out_sel=1.
- rst pulled low in the middle of PAIR -> all outputs 0 immediately; after release, a full frame reproduces the first scenario exactly.
